sfx_sequencer: RTL

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

---
 rtl/sfx_if.sv | 29 ++
 rtl/sfx_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sfx_if.sv
// sfx_if: handshake/bus bundle between the sound-effect sequencer and its environment
// master drives requests, volume pulses and the note table; slave is the sequencer side.
interface sfx_if #(
    parameter int NUM_EVT = 4,
    parameter int LEN_W   = 4,
    parameter int VOL_MAX = 5
);
    localparam int ID_W = NUM_EVT > 1 ? $clog2(NUM_EVT) : 1;
    logic [NUM_EVT-1:0] evt_req;
    logic               mute;
    logic               vol_up;
    logic               vol_dn;
    logic [21:0]        tbl_div;
    logic [LEN_W-1:0]   tbl_len;
    logic [ID_W-1:0]    evt_id;
    logic [LEN_W-1:0]   beat_idx;
    logic               busy;
    logic [21:0]        note_div;
    logic [2:0]         vol;
    logic [VOL_MAX-1:0] vol_led;
    modport master (
        output evt_req, mute, vol_up, vol_dn, tbl_div, tbl_len,
        input  evt_id, beat_idx, busy, note_div, vol, vol_led
    );
    modport slave (
        input  evt_req, mute, vol_up, vol_dn, tbl_div, tbl_len,
        output evt_id, beat_idx, busy, note_div, vol, vol_led
    );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: priority sound-event sequencer stepping through note beats with volume control
// clk, rst (async, active-high) plain ports; bus (sfx_if.slave):
//   in  evt_req, mute, vol_up, vol_dn, tbl_div, tbl_len
//   out evt_id, beat_idx, busy, note_div, vol, vol_led
// Optional macro SFX_QUEUE_EN adds a one-entry pending-event register.
module sfx_sequencer #(
    parameter int NUM_EVT     = 4,
    parameter int BEAT_CYC    = 4194304,
    parameter int LEN_W       = 4,
    parameter int VOL_MAX     = 5,
    parameter int VOL_RST     = 3,
    parameter int SILENCE_DIV = 1
) (
    input logic   clk,
    input logic   rst,
    sfx_if.slave  bus
);
    localparam int ID_W  = NUM_EVT > 1 ? $clog2(NUM_EVT) : 1;
    localparam int CNT_W = BEAT_CYC > 1 ? $clog2(BEAT_CYC) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;
    logic [0:0]       state, state_nx;
    logic [ID_W-1:0]  evt_id, id_nx, req_id;
    logic [LEN_W-1:0] beat_idx, beat_nx, last_idx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       vol, vol_nx;
    logic [21:0]      note_div;
    logic             req_any, tc, seq_end, start;
    logic             pend_vld;
    logic [ID_W-1:0]  pend_id;
`ifdef SFX_QUEUE_EN
    logic             pend_vld_nx;
    logic [ID_W-1:0]  pend_id_nx;
`endif
    always_comb begin
        req_id = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--)
            if (bus.evt_req[i]) req_id = ID_W'(i);
    end
    assign req_any  = |bus.evt_req;
    assign tc       = cnt == CNT_W'(BEAT_CYC - 1);
    // a zero-length table entry plays a single beat
    assign last_idx = bus.tbl_len == '0 ? '0 : bus.tbl_len - 1'b1;
    assign seq_end  = state == PLAY && tc && beat_idx == last_idx;
    // a request coinciding with a sequence end always wins, even a lower-priority one
    assign start    = req_any && (state == IDLE || req_id <= evt_id || seq_end);
    always_comb begin
        state_nx = state;
        id_nx    = evt_id;
        beat_nx  = beat_idx;
        cnt_nx   = cnt;
`ifdef SFX_QUEUE_EN
        pend_vld_nx = pend_vld;
        pend_id_nx  = pend_id;
`endif
        if (start) begin
            state_nx = PLAY;
            id_nx    = req_id;
            beat_nx  = '0;
            cnt_nx   = '0;
`ifdef SFX_QUEUE_EN
            if (pend_id == req_id) pend_vld_nx = 1'b0;
`endif
        end else if (seq_end) begin
            state_nx = pend_vld ? PLAY : IDLE;
            id_nx    = pend_vld ? pend_id : evt_id;
            beat_nx  = '0;
            cnt_nx   = '0;
`ifdef SFX_QUEUE_EN
            pend_vld_nx = 1'b0;
`endif
        end else if (state == PLAY) begin
            cnt_nx  = tc ? '0 : cnt + 1'b1;
            beat_nx = tc ? beat_idx + 1'b1 : beat_idx;
`ifdef SFX_QUEUE_EN
            // only lower-priority requests reach here; keep the best one seen
            if (req_any && (!pend_vld || req_id < pend_id)) begin
                pend_vld_nx = 1'b1;
                pend_id_nx  = req_id;
            end
`endif
        end
    end
    assign vol_nx = (bus.vol_up && !bus.vol_dn && vol < 3'(VOL_MAX)) ? vol + 3'd1 :
                    (bus.vol_dn && !bus.vol_up && vol != 3'd0) ? vol - 3'd1 : vol;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            evt_id   <= '0;
            beat_idx <= '0;
            cnt      <= '0;
            note_div <= 22'(SILENCE_DIV);
            vol      <= 3'(VOL_RST);
        end else begin
            state    <= state_nx;
            evt_id   <= id_nx;
            beat_idx <= beat_nx;
            cnt      <= cnt_nx;
            note_div <= (bus.mute || state_nx == IDLE) ? 22'(SILENCE_DIV) : bus.tbl_div;
            vol      <= vol_nx;
        end
    end
`ifdef SFX_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_id  <= '0;
        end else begin
            pend_vld <= pend_vld_nx;
            pend_id  <= pend_id_nx;
        end
    end
`else
    assign pend_vld = 1'b0;
    assign pend_id  = '0;
`endif
    for (genvar i = 0; i < VOL_MAX; i++) begin : g_led
        assign bus.vol_led[i] = vol > 3'(i);
    end
    assign bus.evt_id   = evt_id;
    assign bus.beat_idx = beat_idx;
    assign bus.busy     = state == PLAY;
    assign bus.note_div = note_div;
    assign bus.vol      = vol;
endmodule
